// File: rtl/alu_share_arbiter.sv
// ----------------------------------------------------------------------------
// alu_share_arbiter
//
// Shares one multi-cycle ALU between two requesters. One operation is in
// flight at a time: the winning requester's operands and opcode are latched,
// the operand mux select is steered toward it, a one-cycle start pulse is
// issued, and the ALU result is returned to that requester with a one-cycle
// response pulse. Ties are broken round-robin (requester 0 wins the first).
//
// Optional feature: define ARB_TIMEOUT_EN to abort a WAIT that lasts
// TIMEOUT_CYCLES cycles without alu_done (response with resp_data=0,
// resp_err=1). Without the macro WAIT holds indefinitely and resp_err is 0.
//
// Ports:
//   clk                    clock, all state on rising edge
//   reset                  asynchronous, active-high reset
//   req_valid[1:0]         requester i has an operation pending
//   req_a0/req_b0/req_op0  operands and opcode of requester 0
//   req_a1/req_b1/req_op1  operands and opcode of requester 1
//   req_ready[1:0]         one-cycle accept pulse to requester i
//   resp_valid[1:0]        one-cycle result pulse to requester i
//   resp_data              result, valid with any resp_valid bit
//   resp_err               timeout flag, valid with resp_valid
//   alu_sel                operand mux select (0 = requester 0)
//   alu_a/alu_b/alu_op     latched operands and opcode to the ALU
//   alu_start              one-cycle ALU start pulse
//   alu_done               ALU result ready (single-cycle pulse)
//   alu_result             ALU result, valid with alu_done
// ----------------------------------------------------------------------------
module alu_share_arbiter #(
  parameter int DATA_WIDTH     = 8,
  parameter int OP_WIDTH       = 2,
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [1:0]            req_valid,
  input  logic [DATA_WIDTH-1:0] req_a0,
  input  logic [DATA_WIDTH-1:0] req_b0,
  input  logic [DATA_WIDTH-1:0] req_a1,
  input  logic [DATA_WIDTH-1:0] req_b1,
  input  logic [OP_WIDTH-1:0]   req_op0,
  input  logic [OP_WIDTH-1:0]   req_op1,
  output logic [1:0]            req_ready,
  output logic [1:0]            resp_valid,
  output logic [DATA_WIDTH-1:0] resp_data,
  output logic                  resp_err,
  output logic                  alu_sel,
  output logic [DATA_WIDTH-1:0] alu_a,
  output logic [DATA_WIDTH-1:0] alu_b,
  output logic [OP_WIDTH-1:0]   alu_op,
  output logic                  alu_start,
  input  logic                  alu_done,
  input  logic [DATA_WIDTH-1:0] alu_result
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t                state_reg, state_next;
  logic                  last_grant_reg;
  logic                  grant;
  logic                  accept;
  logic                  timeout_hit;
  logic                  alu_sel_reg;
  logic [DATA_WIDTH-1:0] alu_a_reg, alu_b_reg, resp_data_reg;
  logic [OP_WIDTH-1:0]   alu_op_reg;
  logic                  resp_err_reg;

  // Grant: a lone requester wins outright; on a tie the one that did not
  // win last time is chosen.
  always_comb begin
    grant = 1'b0;
    case (req_valid)
      2'b10:   grant = 1'b1;
      2'b11:   grant = ~last_grant_reg;
      default: grant = 1'b0;
    endcase
  end

  assign accept = (state_reg == IDLE) && (|req_valid);

  // Next state and pulse outputs. alu_sel_reg carries the current grant
  // from ISSUE through RESP, so it also steers the one-hot pulses.
  always_comb begin
    state_next = state_reg;
    req_ready  = 2'b00;
    resp_valid = 2'b00;
    alu_start  = 1'b0;
    case (state_reg)
      IDLE: begin
        if (|req_valid) state_next = ISSUE;
      end
      ISSUE: begin
        req_ready[alu_sel_reg] = 1'b1;
        alu_start              = 1'b1;
        state_next             = WAIT;
      end
      WAIT: begin
        if (alu_done || timeout_hit) state_next = RESP;
      end
      RESP: begin
        resp_valid[alu_sel_reg] = 1'b1;
        state_next              = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_grant_reg <= 1'b1;
      alu_sel_reg    <= 1'b0;
      alu_a_reg      <= '0;
      alu_b_reg      <= '0;
      alu_op_reg     <= '0;
      resp_data_reg  <= '0;
      resp_err_reg   <= 1'b0;
    end else begin
      if (accept) begin
        last_grant_reg <= grant;
        alu_sel_reg    <= grant;
        alu_a_reg      <= grant ? req_a1  : req_a0;
        alu_b_reg      <= grant ? req_b1  : req_b0;
        alu_op_reg     <= grant ? req_op1 : req_op0;
      end
      // alu_done has priority over an expiring timeout in the same cycle.
      if (state_reg == WAIT) begin
        if (alu_done) begin
          resp_data_reg <= alu_result;
          resp_err_reg  <= 1'b0;
        end else if (timeout_hit) begin
          resp_data_reg <= '0;
          resp_err_reg  <= 1'b1;
        end
      end
    end
  end

  // WAIT watchdog. The counter is cleared in ISSUE so the first WAIT cycle
  // sees 0; expiry is flagged during the TIMEOUT_CYCLES-th WAIT cycle.
  generate
    if (TIMEOUT_CYCLES > 0) begin : g_timeout
`ifdef ARB_TIMEOUT_EN
      localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
      logic [CW-1:0] wait_cnt_reg;

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          wait_cnt_reg <= '0;
        end else if (state_reg == ISSUE) begin
          wait_cnt_reg <= '0;
        end else if (state_reg == WAIT) begin
          wait_cnt_reg <= wait_cnt_reg + 1'b1;
        end
      end

      assign timeout_hit = (state_reg == WAIT) &&
                           (wait_cnt_reg == CW'(TIMEOUT_CYCLES - 1));
`else
      assign timeout_hit = 1'b0;
`endif
    end else begin : g_no_timeout
      assign timeout_hit = 1'b0;
    end
  endgenerate

  assign alu_sel   = alu_sel_reg;
  assign alu_a     = alu_a_reg;
  assign alu_b     = alu_b_reg;
  assign alu_op    = alu_op_reg;
  assign resp_data = resp_data_reg;
  assign resp_err  = resp_err_reg;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// ----------------------------------------------------------------------------
// tb_alu_share_arbiter
//
// The bench plays both requesters and the shared ALU. A transaction-level
// model predicts, from the acceptance cycle N and the chosen ALU latency L,
// when req_ready/alu_start (N+1) and resp_valid (N+2+L) must appear and what
// the latched operands and returned result must be. A compare process checks
// every DUT output on every falling edge; directed sections add literal
// expectations for the headline scenarios.
// ----------------------------------------------------------------------------
module tb_alu_share_arbiter;

  localparam int DW  = 8;
  localparam int OW  = 2;
  localparam int TMO = 15;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [1:0]    req_valid;
  logic [DW-1:0] req_a0, req_b0, req_a1, req_b1;
  logic [OW-1:0] req_op0, req_op1;
  logic [1:0]    req_ready, resp_valid;
  logic [DW-1:0] resp_data;
  logic          resp_err;
  logic          alu_sel;
  logic [DW-1:0] alu_a, alu_b;
  logic [OW-1:0] alu_op;
  logic          alu_start;
  logic          alu_done;
  logic [DW-1:0] alu_result;

  alu_share_arbiter #(
    .DATA_WIDTH(DW),
    .OP_WIDTH(OW),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk),
    .reset(reset),
    .req_valid(req_valid),
    .req_a0(req_a0),
    .req_b0(req_b0),
    .req_a1(req_a1),
    .req_b1(req_b1),
    .req_op0(req_op0),
    .req_op1(req_op1),
    .req_ready(req_ready),
    .resp_valid(resp_valid),
    .resp_data(resp_data),
    .resp_err(resp_err),
    .alu_sel(alu_sel),
    .alu_a(alu_a),
    .alu_b(alu_b),
    .alu_op(alu_op),
    .alu_start(alu_start),
    .alu_done(alu_done),
    .alu_result(alu_result)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  // Requester state
  logic          pend [2];
  logic [DW-1:0] pa   [2];
  logic [DW-1:0] pb   [2];
  logic [OW-1:0] pop  [2];

  // Transaction model
  logic          m_busy;
  logic          m_g;
  logic          m_last;
  int            m_n, m_done, m_resp;
  logic [DW-1:0] m_res;
  logic          m_err;
  logic [DW-1:0] s_a, s_b;
  logic [OW-1:0] s_op;

  // Expected outputs for the current cycle
  logic [1:0]    e_ready, e_resp;
  logic          e_start, e_sel, e_err;
  logic [DW-1:0] e_a, e_b, e_rd;
  logic [OW-1:0] e_op;

  // Stimulus controls
  logic rnd_mode = 1'b0;
  logic stray_en = 1'b0;
  logic chk_en   = 1'b0;
  int   force_lat = 1;

  function automatic logic [DW-1:0] alu_fn(logic [OW-1:0] op, logic [DW-1:0] a, logic [DW-1:0] b);
    case (op)
      2'd0:    return a + b;
      2'd1:    return a - b;
      2'd2:    return a ^ b;
      default: return a & b;
    endcase
  endfunction

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d actual=0x%0h required=0x%0h", name, cyc, act, exp);
    end
  endfunction

  function automatic void bound_fail(string name);
    checks++;
    errors++;
    $display("FAIL %s cyc=%0d actual=no-event required=event-within-bound", name, cyc);
  endfunction

  task automatic drive_inputs();
    req_valid = {pend[1], pend[0]};
    req_a0 = pa[0]; req_b0 = pb[0]; req_op0 = pop[0];
    req_a1 = pa[1]; req_b1 = pb[1]; req_op1 = pop[1];
  endtask

  task automatic model_init();
    m_busy = 1'b0; m_last = 1'b1; m_g = 1'b0;
    m_n = 0; m_done = 0; m_resp = 0;
    e_ready = 2'b00; e_resp = 2'b00; e_start = 1'b0; e_sel = 1'b0; e_err = 1'b0;
    e_a = '0; e_b = '0; e_rd = '0; e_op = '0;
    for (int i = 0; i < 2; i++) begin
      pend[i] = 1'b0; pa[i] = '0; pb[i] = '0; pop[i] = '0;
    end
    drive_inputs();
    alu_done = 1'b0;
    alu_result = '0;
  endtask

  // One cycle of stimulus and prediction, called just after a rising edge.
  task automatic step();
    logic g;
    logic in_wait;
    int   lat;
    cyc++;
    if (m_busy && cyc == m_resp + 1) m_busy = 1'b0;
    if (m_busy && cyc == m_n + 2) pend[m_g] = 1'b0;
    if (m_busy && cyc == m_n + 1) begin
      e_sel = m_g; e_a = s_a; e_b = s_b; e_op = s_op;
    end
    if (m_busy && cyc == m_resp) begin
      e_rd = m_res; e_err = m_err;
    end
    e_ready = (m_busy && cyc == m_n + 1) ? (m_g ? 2'b10 : 2'b01) : 2'b00;
    e_start = m_busy && (cyc == m_n + 1);
    e_resp  = (m_busy && cyc == m_resp) ? (m_g ? 2'b10 : 2'b01) : 2'b00;

    for (int i = 0; i < 2; i++) begin
      if (!pend[i]) begin
        pa[i] = DW'($urandom); pb[i] = DW'($urandom); pop[i] = OW'($urandom);
        if (rnd_mode && $urandom_range(0, 2) == 0) pend[i] = 1'b1;
      end
    end
    drive_inputs();

    in_wait = m_busy && (cyc >= m_n + 2) && (cyc < m_resp);
    if (m_busy && cyc == m_done && m_done < m_resp) begin
      alu_done = 1'b1; alu_result = m_res;
    end else begin
      alu_done   = !in_wait && stray_en && ($urandom_range(0, 3) == 0);
      alu_result = DW'($urandom);
    end

    if (!m_busy && (pend[0] || pend[1])) begin
      g = (pend[0] && pend[1]) ? ~m_last : pend[1];
      m_last = g; m_g = g; m_n = cyc;
      s_a = pa[g]; s_b = pb[g]; s_op = pop[g];
      lat = rnd_mode ? int'($urandom_range(1, 6)) : force_lat;
      m_done = cyc + 1 + lat;
      m_resp = m_done + 1;
      m_res  = alu_fn(s_op, s_a, s_b);
      m_err  = 1'b0;
`ifdef ARB_TIMEOUT_EN
      if (lat > TMO) begin
        m_resp = cyc + 2 + TMO;
        m_res  = '0;
        m_err  = 1'b1;
      end
`endif
      m_busy = 1'b1;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    step();
  endtask

  task automatic do_reset();
    chk_en = 1'b0;
    reset  = 1'b1;
    #1;
    check("rst_req_ready",  32'(req_ready),  32'(0));
    check("rst_resp_valid", 32'(resp_valid), 32'(0));
    check("rst_resp_data",  32'(resp_data),  32'(0));
    check("rst_resp_err",   32'(resp_err),   32'(0));
    check("rst_alu_sel",    32'(alu_sel),    32'(0));
    check("rst_alu_a",      32'(alu_a),      32'(0));
    check("rst_alu_b",      32'(alu_b),      32'(0));
    check("rst_alu_op",     32'(alu_op),     32'(0));
    check("rst_alu_start",  32'(alu_start),  32'(0));
    model_init();
    @(posedge clk);
    #1;
    reset  = 1'b0;
    chk_en = 1'b1;
  endtask

  // Compare process: all outputs against the model every cycle.
  always @(negedge clk) begin
    if (chk_en) begin
      check("req_ready",  32'(req_ready),  32'(e_ready));
      check("resp_valid", 32'(resp_valid), 32'(e_resp));
      check("alu_start",  32'(alu_start),  32'(e_start));
      check("alu_sel",    32'(alu_sel),    32'(e_sel));
      check("alu_a",      32'(alu_a),      32'(e_a));
      check("alu_b",      32'(alu_b),      32'(e_b));
      check("alu_op",     32'(alu_op),     32'(e_op));
      check("resp_data",  32'(resp_data),  32'(e_rd));
      check("resp_err",   32'(resp_err),   32'(e_err));
    end
  end

  logic [1:0] exp_rr [3];
  int         n0;
  logic       found;
  logic       gg;

  initial begin
    exp_rr[0] = 2'b01; exp_rr[1] = 2'b10; exp_rr[2] = 2'b01;
    model_init();
    #3;
    do_reset();

    // Single request on requester 0, ALU latency 1: 0x12 + 0x34.
    force_lat = 1;
    pend[0] = 1'b1; pa[0] = 8'h12; pb[0] = 8'h34; pop[0] = 2'd0;
    tick();
    n0 = cyc;
    tick();
    @(negedge clk);
    check("single_ready_n1", 32'(req_ready), 32'(2'b01));
    check("single_sel",      32'(alu_sel),   32'(0));
    tick();
    tick();
    @(negedge clk);
    check("single_resp_n3", 32'(resp_valid), 32'(2'b01));
    check("single_data",    32'(resp_data),  32'(8'h46));
    check("single_cycle",   32'(cyc - n0),   32'(3));
    tick();

    // Tie fairness from reset: grants 0,1,0.
    do_reset();
    pend[0] = 1'b1; pend[1] = 1'b1;
    for (int t = 0; t < 3; t++) begin
      found = 1'b0;
      for (int k = 0; k < 12; k++) begin
        tick();
        @(negedge clk);
        if (req_ready != 2'b00) begin
          found = 1'b1;
          break;
        end
      end
      if (!found) bound_fail("tie_wait");
      check("tie_grant", 32'(req_ready), 32'(exp_rr[t]));
      check("tie_sel",   32'(alu_sel),   32'(exp_rr[t][1]));
      gg = alu_sel;
      tick();
      if (t < 2) pend[gg] = 1'b1;
    end
    repeat (12) tick();

    // Multi-cycle ALU on requester 1: resp 7 cycles after request sampled.
    force_lat = 5;
    pend[1] = 1'b1;
    tick();
    n0 = cyc;
    found = 1'b0;
    for (int k = 0; k < 20; k++) begin
      tick();
      @(negedge clk);
      check("mc_sel_hold", 32'(alu_sel), 32'(1));
      if (resp_valid != 2'b00) begin
        found = 1'b1;
        break;
      end
    end
    if (!found) bound_fail("mc_wait");
    check("mc_latency", 32'(cyc - n0),   32'(7));
    check("mc_resp",    32'(resp_valid), 32'(2'b10));
    tick();

    // Stray alu_done pulses while idle, then around a transaction.
    stray_en = 1'b1;
    for (int k = 0; k < 6; k++) begin
      tick();
      @(negedge clk);
      check("stray_idle", 32'(resp_valid), 32'(0));
    end
    force_lat = 3;
    pend[0] = 1'b1;
    repeat (10) tick();

    // Randomised traffic.
    rnd_mode = 1'b1;
    repeat (2000) tick();
    rnd_mode = 1'b0;
    repeat (40) tick();
    stray_en = 1'b0;

    // Reset in the middle of WAIT: nothing comes back afterwards.
    force_lat = 20;
    pend[0] = 1'b1;
    repeat (4) tick();
    @(negedge clk);
    do_reset();
    for (int k = 0; k < 10; k++) begin
      tick();
      @(negedge clk);
      check("post_rst_resp", 32'(resp_valid), 32'(0));
    end

    // ALU never answers.
    force_lat = 200;
    pend[0] = 1'b1;
    tick();
    n0 = cyc;
`ifdef ARB_TIMEOUT_EN
    found = 1'b0;
    for (int k = 0; k < 30; k++) begin
      tick();
      @(negedge clk);
      if (resp_valid != 2'b00) begin
        found = 1'b1;
        break;
      end
    end
    if (!found) bound_fail("tmo_wait");
    check("tmo_latency", 32'(cyc - n0),  32'(TMO + 2));
    check("tmo_err",     32'(resp_err),  32'(1));
    check("tmo_data",    32'(resp_data), 32'(0));
    tick();
`else
    for (int k = 0; k < 100; k++) begin
      tick();
      @(negedge clk);
      check("hang_no_resp", 32'(resp_valid), 32'(0));
    end
    do_reset();
`endif
    repeat (3) tick();
    @(negedge clk);
    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
